frame_pacer: RTL and testbench



---
 rtl/frame_pacer_pkg.sv | 14 +
 rtl/frame_pacer.sv | 132 +++++++++++++
 tb/tb_frame_pacer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_pacer_pkg.sv
// rtl/frame_pacer_pkg.sv - shared state, mode and width definitions for frame_pacer
package frame_pkg;

  typedef enum logic {
    FP_IDLE = 1'b0,
    FP_RUN  = 1'b1
  } fp_state_e;

  localparam logic FP_PERIODIC = 1'b0;
  localparam logic FP_ONESHOT  = 1'b1;

  localparam int unsigned WRAP_W = 8;

endpackage

// File: rtl/frame_pacer.sv
// rtl/frame_pacer.sv - counts frame ticks against a shadowed period, pulses enable_out at terminal count
// Define FRAME_PACER_WRAPCNT_EN to add the saturating wrap_cnt output.
module frame_pacer
  import frame_pkg::*;
#(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned DEFAULT_PERIOD = 15
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             period_ld,
  input  logic [CNT_W-1:0] period_in,
  output logic             enable_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef FRAME_PACER_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_PERIOD);

  fp_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic             at_terminal;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    period_d    = period_q;
    shadow_d    = shadow_q;
    enable_d    = 1'b0;
    done_d      = done_q;
    mode_d      = mode_q;
    at_terminal = (count_q == period_q);

    // In RUN a new period waits in the shadow until the current cycle wraps.
    if (period_ld) begin
      shadow_d = period_in;
      if (state_q == FP_IDLE) begin
        period_d = period_in;
      end
    end

    if (stop) begin
      state_d = FP_IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = FP_RUN;
      count_d = '0;
      mode_d  = mode;
      done_d  = 1'b0;
    end else if ((state_q == FP_RUN) && frame_tick) begin
      if (at_terminal) begin
        count_d  = '0;
        enable_d = 1'b1;
        period_d = period_ld ? period_in : shadow_q;
        if (mode_q == FP_ONESHOT) begin
          state_d = FP_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    busy_d = (state_d == FP_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FP_IDLE;
      count_q  <= '0;
      period_q <= PERIOD_RST;
      shadow_q <= PERIOD_RST;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= FP_PERIODIC;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      shadow_q <= shadow_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

  assign enable_out = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = count_q;

`ifdef FRAME_PACER_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (!stop && start) begin
      wrap_cnt_d = '0;
    end else if (enable_d && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_frame_pacer.sv
// tb/tb_frame_pacer.sv - directed vector bench for frame_pacer
module tb_frame_pacer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick, start, stop, mode, period_ld;
  logic [3:0] period_in;
  logic       enable_out, busy, done;
  logic [3:0] count;
`ifdef FRAME_PACER_WRAPCNT_EN
  logic [7:0] wrap_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_pacer #(.CNT_W(4), .DEFAULT_PERIOD(15)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .period_ld  (period_ld),
    .period_in  (period_in),
    .enable_out (enable_out),
    .busy       (busy),
    .done       (done),
    .count      (count)
`ifdef FRAME_PACER_WRAPCNT_EN
    ,
    .wrap_cnt   (wrap_cnt)
`endif
  );

  typedef struct packed {
    logic       ft, st, sp, md, ld;
    logic [3:0] pin;
    logic       en, bsy, dn;
    logic [3:0] cnt;
  } vec_t;

  localparam int NVEC = 31;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic ft, logic st, logic sp, logic md, logic ld, logic [3:0] pin,
                              logic en, logic bsy, logic dn, logic [3:0] cnt);
    vec_t v;
    v.ft = ft; v.st = st; v.sp = sp; v.md = md; v.ld = ld; v.pin = pin;
    v.en = en; v.bsy = bsy; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic bsy, input logic dn, input logic [3:0] cnt);
    chk({tag, ".enable_out"}, {7'd0, enable_out}, {7'd0, en});
    chk({tag, ".busy"},       {7'd0, busy},       {7'd0, bsy});
    chk({tag, ".done"},       {7'd0, done},       {7'd0, dn});
    chk({tag, ".count"},      {4'd0, count},      {4'd0, cnt});
  endtask

  // Inputs are held for one clock edge, then cleared; outputs are sampled 1ns after the edge.
  task automatic drive(input logic ft, input logic st, input logic sp, input logic md,
                       input logic ld, input logic [3:0] pin);
    frame_tick = ft; start = st; stop = sp; mode = md; period_ld = ld; period_in = pin;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period_ld = 1'b0; period_in = 4'd0;
  endtask

  task automatic tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    // Fields: ft st sp md ld pin | en busy done cnt
    tbl[0]  = mk(0,0,0,0,1,4'd2,  0,0,0,4'd0);
    tbl[1]  = mk(0,1,0,1,0,4'd0,  0,1,0,4'd0);
    tbl[2]  = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[3]  = mk(0,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[4]  = mk(1,0,0,0,0,4'd0,  0,1,0,4'd2);
    tbl[5]  = mk(1,0,0,0,0,4'd0,  1,0,1,4'd0);
    tbl[6]  = mk(0,0,0,0,0,4'd0,  0,0,1,4'd0);
    tbl[7]  = mk(1,0,0,0,0,4'd0,  0,0,1,4'd0);
    tbl[8]  = mk(0,1,0,0,0,4'd0,  0,1,0,4'd0);
    tbl[9]  = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[10] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd2);
    tbl[11] = mk(1,0,0,0,0,4'd0,  1,1,0,4'd0);
    tbl[12] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[13] = mk(0,1,0,0,0,4'd0,  0,1,0,4'd0);
    tbl[14] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[15] = mk(0,0,0,0,1,4'd0,  0,1,0,4'd1);
    tbl[16] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd2);
    tbl[17] = mk(1,0,0,0,0,4'd0,  1,1,0,4'd0);
    tbl[18] = mk(1,0,0,0,0,4'd0,  1,1,0,4'd0);
    tbl[19] = mk(1,0,0,0,0,4'd0,  1,1,0,4'd0);
    tbl[20] = mk(1,0,0,0,1,4'd1,  1,1,0,4'd0);
    tbl[21] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[22] = mk(1,0,0,0,0,4'd0,  1,1,0,4'd0);
    tbl[23] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[24] = mk(1,0,1,0,0,4'd0,  0,0,0,4'd0);
    tbl[25] = mk(0,1,1,0,0,4'd0,  0,0,0,4'd0);
    tbl[26] = mk(1,0,0,0,0,4'd0,  0,0,0,4'd0);
    tbl[27] = mk(0,1,0,1,0,4'd0,  0,1,0,4'd0);
    tbl[28] = mk(1,0,0,0,0,4'd0,  0,1,0,4'd1);
    tbl[29] = mk(1,0,1,0,0,4'd0,  0,0,0,4'd0);
    tbl[30] = mk(0,0,0,0,1,4'd15, 0,0,0,4'd0);

    resetn = 1'b0;
    frame_tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period_ld = 1'b0; period_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    resetn = 1'b1;
    idle();

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].ft, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].ld, tbl[i].pin);
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].bsy, tbl[i].dn, tbl[i].cnt);
    end

    // Periodic, period 15, one tick every 4 clocks: pulses on ticks 16, 32, 48.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("per.start_busy", {7'd0, busy}, 8'd1);
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk($sformatf("per.t%0d.en", k), {7'd0, enable_out}, {7'd0, (k % 16) == 0});
      chk($sformatf("per.t%0d.cnt", k), {4'd0, count}, 8'(k % 16));
      chk($sformatf("per.t%0d.busy", k), {7'd0, busy}, 8'd1);
      idle();
      chk($sformatf("per.t%0d.en_off", k), {7'd0, enable_out}, 8'd0);
      idle();
      idle();
    end

    // Load period 3 mid-cycle at count 5: old cycle runs to 15, then every 4 ticks.
    for (int k = 1; k <= 5; k++) tick();
    chk("ld.pre_cnt", {4'd0, count}, 8'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    chk("ld.hold_cnt", {4'd0, count}, 8'd5);
    for (int j = 1; j <= 19; j++) begin
      tick();
      if (j < 11) begin
        chk($sformatf("ld.j%0d.cnt", j), {4'd0, count}, 8'(5 + j));
        chk($sformatf("ld.j%0d.en", j), {7'd0, enable_out}, 8'd0);
      end else begin
        chk($sformatf("ld.j%0d.cnt", j), {4'd0, count}, 8'((j - 11) % 4));
        chk($sformatf("ld.j%0d.en", j), {7'd0, enable_out}, {7'd0, ((j - 11) % 4) == 0});
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk_all("ld.stop", 1'b0, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset mid-RUN at count 7 restores the default period.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 7; k++) tick();
    chk("arst.pre_cnt", {4'd0, count}, 8'd7);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_all("arst.async", 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 15; k++) tick();
    chk_all("arst.t15", 1'b0, 1'b1, 1'b0, 4'd15);
    tick();
    chk_all("arst.t16", 1'b1, 1'b1, 1'b0, 4'd0);
    idle();
    chk("arst.en_off", {7'd0, enable_out}, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

`ifdef FRAME_PACER_WRAPCNT_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("wrap.cleared", wrap_cnt, 8'd0);
    for (int k = 1; k <= 300; k++) tick();
    chk("wrap.saturate", wrap_cnt, 8'd255);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("wrap.restart", wrap_cnt, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
